// File: rtl/raisin64_pkg.sv
// Shared Raisin64 definitions: stream geometry and the instruction length decode
// used by both fetch alignment and decode's advance generation.
package raisin64_pkg;

   localparam int HW_PER_WORD = 4;
   localparam int BUF_HW      = 8;

   typedef logic [3:0] hw_cnt_t;

   // Halfword count of the instruction whose first halfword starts with top[1:0].
   function automatic logic [2:0] inst_len_hw(input logic [1:0] top);
      logic [2:0] len;
      if (!top[1])
         len = 3'd1;
      else if (!top[0])
         len = 3'd2;
      else
         len = 3'd4;
      return len;
   endfunction

endpackage

// File: rtl/fa_shiftbuf.sv
// Head-aligned 8-halfword buffer: consumes from the head, appends a fetched word
// (minus leading skipped halfwords) after the surviving contents.
module fa_shiftbuf
   import raisin64_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [2:0]  adv_hw,
   input  logic        append,
   input  logic [63:0] word,
   input  logic [1:0]  skip,
   output logic [63:0] inst,
   output logic        inst_valid,
   output hw_cnt_t     cnt_next
);

   logic [127:0] buf_q;
   logic [127:0] buf_next;
   logic [127:0] post;
   logic [127:0] ins;
   logic [63:0]  word_sh;
   hw_cnt_t      cnt_q;
   hw_cnt_t      cnt_a;
   logic         valid_next;

   // Halfwords past cnt are always zero, so the append can simply OR in.
   always_comb begin
      post     = buf_q << {adv_hw, 4'b0000};
      cnt_a    = (cnt_q >= {1'b0, adv_hw}) ? cnt_q - {1'b0, adv_hw} : 4'd0;
      word_sh  = word << {skip, 4'b0000};
      ins      = {word_sh, 64'd0} >> {cnt_a, 4'b0000};
      buf_next = post;
      cnt_next = cnt_a;
      if (flush) begin
         buf_next = '0;
         cnt_next = '0;
      end else if (append) begin
         buf_next = post | ins;
         cnt_next = cnt_a + 4'(HW_PER_WORD) - {2'b00, skip};
      end
      valid_next = (cnt_next != 4'd0) &&
                   (cnt_next >= {1'b0, inst_len_hw(buf_next[127:126])});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q      <= '0;
         cnt_q      <= '0;
         inst_valid <= 1'b0;
      end else begin
         buf_q      <= buf_next;
         cnt_q      <= cnt_next;
         inst_valid <= valid_next;
      end
   end

   assign inst = buf_q[127:64];

endmodule

// File: rtl/fetch_align.sv
// Instruction fetch alignment buffer: one-outstanding-request fetch FSM feeding
// a halfword shift buffer that presents the instruction at inst_pc to decode.
module fetch_align
   import raisin64_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance16,
   input  logic        advance32,
   input  logic        advance64,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic [63:0] inst,
   output logic        inst_valid,
   output logic [63:0] inst_pc,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [63:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   logic [1:0]  state_q;
   logic [63:0] fetch_addr_q;
   logic [1:0]  skip_q;
   logic [2:0]  adv_hw;
   logic        append;
   hw_cnt_t     cnt_next;
   logic [63:0] rpc_word;
   logic        unused_rpc_bit0;

   assign rpc_word        = {redirect_pc[63:3], 3'b000};
   assign unused_rpc_bit0 = redirect_pc[0];
   assign mem_req         = (state_q != ST_IDLE);

   // Advance only takes effect on a complete head instruction; redirect overrides it.
   always_comb begin
      adv_hw = 3'd0;
      if (inst_valid && !redirect) begin
         if (advance16)
            adv_hw = 3'd1;
         else if (advance32)
            adv_hw = 3'd2;
         else if (advance64)
            adv_hw = 3'd4;
      end
   end

   assign append = mem_ack && (state_q == ST_REQ) && !redirect;

   fa_shiftbuf u_shiftbuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .adv_hw     (adv_hw),
      .append     (append),
      .word       (mem_rdata),
      .skip       (skip_q),
      .inst       (inst),
      .inst_valid (inst_valid),
      .cnt_next   (cnt_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_pc      <= {RESET_PC[63:1], 1'b0};
         fetch_addr_q <= {RESET_PC[63:3], 3'b000};
         skip_q       <= RESET_PC[2:1];
      end else if (redirect) begin
         inst_pc      <= {redirect_pc[63:1], 1'b0};
         fetch_addr_q <= rpc_word;
         skip_q       <= redirect_pc[2:1];
      end else begin
         inst_pc <= inst_pc + {60'd0, adv_hw, 1'b0};
         if (append) begin
            fetch_addr_q <= fetch_addr_q + 64'd8;
            skip_q       <= 2'b00;
         end
      end
   end

   // A redirect that finds the bus idle (or sees the pending ack) issues its
   // target immediately; otherwise the in-flight request is finished and dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         mem_addr <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (redirect) begin
                  state_q  <= ST_REQ;
                  mem_addr <= rpc_word;
               end else if (cnt_next <= 4'(HW_PER_WORD)) begin
                  state_q  <= ST_REQ;
                  mem_addr <= fetch_addr_q;
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  if (redirect) begin
                     state_q  <= ST_REQ;
                     mem_addr <= rpc_word;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (redirect) begin
                  state_q <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (mem_ack) begin
                  state_q  <= ST_REQ;
                  mem_addr <= redirect ? rpc_word : fetch_addr_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_align.sv
// Directed table bench for fetch_align with RESET_PC=0x1000, plus hand-written
// reset-abandon and post-reset fetch sequences.
module tb_fetch_align;

   logic        clk;
   logic        rst_n;
   logic        advance16, advance32, advance64;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [63:0] inst;
   logic        inst_valid;
   logic [63:0] inst_pc;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_rdata;

   int tests;
   int fails;

   typedef struct {
      logic        rd;
      logic [63:0] rpc;
      logic [1:0]  adv;     // 0 none, 1 adv16, 2 adv32, 3 adv64
      logic        ack;
      logic [63:0] rdata;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_valid;
      logic [63:0] e_inst;
      logic [63:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   fetch_align #(.RESET_PC(64'h1000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .advance16   (advance16),
      .advance32   (advance32),
      .advance64   (advance64),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst        (inst),
      .inst_valid  (inst_valid),
      .inst_pc     (inst_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic rd, input logic [63:0] rpc, input logic [1:0] adv,
                      input logic ack, input logic [63:0] rdata, input logic e_req,
                      input logic [63:0] e_addr, input logic e_valid,
                      input logic [63:0] e_inst, input logic [63:0] e_pc);
      vec_t v;
      v.rd = rd; v.rpc = rpc; v.adv = adv; v.ack = ack; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_inst = e_inst; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rd, input logic [63:0] rpc, input logic [1:0] adv,
                        input logic ack, input logic [63:0] rdata);
      redirect    = rd;
      redirect_pc = rpc;
      advance16   = (adv == 2'd1);
      advance32   = (adv == 2'd2);
      advance64   = (adv == 2'd3);
      mem_ack     = ack;
      mem_rdata   = rdata;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      drive(1'b0, 64'd0, 2'd0, 1'b0, 64'd0);

      // Each row: inputs held for one cycle, outputs expected in that same cycle.
      add(0, 0, 0, 1, 64'h8001_2345_0003_C000, 1, 64'h1000, 0, 64'h0, 64'h1000);
      add(0, 0, 2, 0, 0, 0, 0, 1, 64'h8001_2345_0003_C000, 64'h1000);
      add(0, 0, 1, 0, 0, 1, 64'h1008, 1, 64'h0003_C000_0000_0000, 64'h1004);
      add(0, 0, 3, 0, 0, 1, 64'h1008, 0, 64'hC000_0000_0000_0000, 64'h1006);
      add(0, 0, 0, 1, 64'h1111_2222_3333_4444, 1, 64'h1008, 0, 64'hC000_0000_0000_0000, 64'h1006);
      add(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 64'hC000_1111_2222_3333, 64'h1006);
      add(0, 0, 3, 0, 0, 0, 0, 1, 64'hC000_1111_2222_3333, 64'h1006);
      add(0, 0, 0, 1, 64'h0005_0006_0007_0008, 1, 64'h1010, 1, 64'h4444_0000_0000_0000, 64'h100E);
      add(0, 0, 0, 0, 0, 0, 0, 1, 64'h4444_0005_0006_0007, 64'h100E);
      add(0, 0, 1, 0, 0, 0, 0, 1, 64'h4444_0005_0006_0007, 64'h100E);
      add(0, 0, 2, 1, 64'h000A_000B_000C_000D, 1, 64'h1018, 1, 64'h0005_0006_0007_0008, 64'h1010);
      add(0, 0, 0, 0, 0, 0, 0, 1, 64'h0007_0008_000A_000B, 64'h1014);
      add(0, 0, 3, 0, 0, 0, 0, 1, 64'h0007_0008_000A_000B, 64'h1014);
      add(1, 64'h2006, 0, 0, 0, 1, 64'h1020, 1, 64'h000C_000D_0000_0000, 64'h101C);
      add(0, 0, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 1, 64'h1020, 0, 64'h0, 64'h2006);
      add(0, 0, 0, 1, 64'h1234_5678_9ABC_8765, 1, 64'h2000, 0, 64'h0, 64'h2006);
      add(0, 0, 2, 0, 0, 0, 0, 0, 64'h8765_0000_0000_0000, 64'h2006);
      add(0, 0, 0, 1, 64'h4321_0001_0002_0003, 1, 64'h2008, 0, 64'h8765_0000_0000_0000, 64'h2006);
      add(0, 0, 2, 0, 0, 0, 0, 1, 64'h8765_4321_0001_0002, 64'h2006);
      add(1, 64'h3002, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h2010, 1, 64'h0001_0002_0003_0000, 64'h200A);
      add(0, 0, 0, 1, 64'hAAAA_0040_0050_0060, 1, 64'h3000, 0, 64'h0, 64'h3002);
      add(1, 64'h4001, 0, 0, 0, 0, 0, 1, 64'h0040_0050_0060_0000, 64'h3002);
      add(0, 0, 0, 0, 0, 1, 64'h4000, 0, 64'h0, 64'h4000);
      add(0, 0, 0, 0, 0, 1, 64'h4000, 0, 64'h0, 64'h4000);

      repeat (2) @(negedge clk);
      chk("rst_req",   0, {63'd0, mem_req}, 64'd0);
      chk("rst_addr",  0, mem_addr, 64'd0);
      chk("rst_valid", 0, {63'd0, inst_valid}, 64'd0);
      chk("rst_inst",  0, inst, 64'd0);
      chk("rst_pc",    0, inst_pc, 64'h1000);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         chk("req",   i, {63'd0, mem_req}, {63'd0, vecs[i].e_req});
         if (vecs[i].e_req)
            chk("addr", i, mem_addr, vecs[i].e_addr);
         chk("valid", i, {63'd0, inst_valid}, {63'd0, vecs[i].e_valid});
         chk("inst",  i, inst, vecs[i].e_inst);
         chk("pc",    i, inst_pc, vecs[i].e_pc);
         drive(vecs[i].rd, vecs[i].rpc, vecs[i].adv, vecs[i].ack, vecs[i].rdata);
      end

      // Reset while the request at 0x4000 is outstanding abandons it.
      @(negedge clk);
      drive(1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_req",   0, {63'd0, mem_req}, 64'd0);
      chk("arst_valid", 0, {63'd0, inst_valid}, 64'd0);
      chk("arst_pc",    0, inst_pc, 64'h1000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4 && !mem_req; k++) @(negedge clk);
      chk("post_rst_req",  0, {63'd0, mem_req}, 64'd1);
      chk("post_rst_addr", 0, mem_addr, 64'h1000);
      drive(1'b0, 64'd0, 2'd0, 1'b1, 64'h8001_2345_0003_C000);
      @(negedge clk);
      drive(1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
      chk("post_rst_valid", 0, {63'd0, inst_valid}, 64'd1);
      chk("post_rst_inst",  0, {32'd0, inst[63:32]}, 64'h8001_2345);
      chk("post_rst_pc",    0, inst_pc, 64'h1000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
